// File: rtl/apb4_slave_mem_pkg.sv
// Shared types and helpers for the APB4 completer memory.
package apb4_slave_mem_pkg;

  // Transfer state of the completer.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // Error classes, listed in decode priority order.
  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_RANGE,
    ERR_ALIGN,
    ERR_RO
  } apb_err_e;

  // Widest supported data bus; narrower buses zero-extend into the helper.
  localparam int MAX_DATA_WIDTH = 32;
  localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;
  localparam int WAIT_CNT_WIDTH = 4;

  // Replace the bytes of old_word selected by strb with the matching bytes of new_word.
  function automatic logic [MAX_DATA_WIDTH-1:0] strb_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_STRB_WIDTH-1:0] strb
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_STRB_WIDTH; i++) begin
      if (strb[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/apb4_slave_mem_if.sv
// APB4 bus segment between one requester and this completer.
interface apb4_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic                    PREADY;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PSLVERR;

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR
  );

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR
  );

endinterface

// File: rtl/apb4_slave_mem_bytemem.sv
// Word memory with per-byte write enables, synchronous clear and asynchronous read.
module apb4_slave_mem_bytemem
  import apb4_slave_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int STRB_W    = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  clr_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      widx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_W-1:0]     strb_i,
  input  logic [IDX_W-1:0]      ridx_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0]     mem_q [DEPTH];
  logic [MAX_DATA_WIDTH-1:0] old_ext;
  logic [MAX_DATA_WIDTH-1:0] new_ext;
  logic [MAX_DATA_WIDTH-1:0] merged;
  logic [MAX_STRB_WIDTH-1:0] strb_ext;

  // Build the byte-merged word that a strobed write stores.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    old_ext  = '0;
    new_ext  = '0;
    strb_ext = '0;
    old_ext[DATA_WIDTH-1:0] = mem_q[widx_i];
    new_ext[DATA_WIDTH-1:0] = wdata_i;
    strb_ext[STRB_W-1:0]    = strb_i;
    merged = strb_merge(old_ext, new_ext, strb_ext);
  end

  assign rdata_o = mem_q[ridx_i];

  // Storage update: clear wins over write.
  // NOTE: the array is cleared on reset because a reset must read back as all-zero words;
  // this costs a clear path on every word and rules out mapping onto plain SRAM macros.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[widx_i] <= merged[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/apb4_slave_mem.sv
// APB4 completer over a byte-strobed word memory: transfer FSM, capture registers,
// wait-state counter, error decode and bus protocol checker.
module apb4_slave_mem
  import apb4_slave_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0,
  parameter int RO_BASE     = 0,
  parameter int RO_WORDS    = 0
) (
  input  logic             PCLK,
  input  logic             PRESET,
  apb4_slave_mem_if.slave  bus,
  output logic             proto_err
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(STRB_W - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] RO_LO    = ADDR_WIDTH'(RO_BASE);
  localparam logic [ADDR_WIDTH-1:0] RO_N     = ADDR_WIDTH'(RO_WORDS);

  // The counter holds the WAIT cycles still to come after the current one, so a
  // zero-wait transfer skips WAIT and raises PREADY in its first access cycle.
  localparam logic [WAIT_CNT_WIDTH-1:0] WS_RELOAD =
    (WAIT_STATES == 0) ? '0 : WAIT_CNT_WIDTH'(WAIT_STATES - 1);

  state_e                    state_q,     state_d;
  logic [WAIT_CNT_WIDTH-1:0] cnt_q,       cnt_d;
  logic [ADDR_WIDTH-1:0]     cap_addr_q,  cap_addr_d;
  logic                      cap_write_q, cap_write_d;
  logic [DATA_WIDTH-1:0]     cap_wdata_q, cap_wdata_d;
  logic [STRB_W-1:0]         cap_strb_q,  cap_strb_d;
  logic                      pready_q,    pready_d;
  logic [DATA_WIDTH-1:0]     prdata_q,    prdata_d;
  logic                      pslverr_q,   pslverr_d;
  logic                      proto_q,     proto_d;

  logic                  resp_load;
  logic [ADDR_WIDTH-1:0] t_addr;
  logic [ADDR_WIDTH-1:0] t_word;
  logic                  t_write;
  apb_err_e              t_err;
  logic                  ro_hit;
  logic                  bus_differs;
  logic [IDX_W-1:0]      t_idx;
  logic [IDX_W-1:0]      cap_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  mem_we;

  // In IDLE the response is decoded straight from the setup-phase bus (zero-wait);
  // afterwards only the captured copy is trusted.
  always_comb begin
    t_addr  = cap_addr_q;
    t_write = cap_write_q;
    if (state_q == IDLE) begin
      t_addr  = bus.PADDR;
      t_write = bus.PWRITE;
    end
  end

  assign t_word  = t_addr >> OFF_W;
  assign t_idx   = IDX_W'(t_word);
  assign cap_idx = IDX_W'(cap_addr_q >> OFF_W);

  // Read-only window membership via a borrow-checked offset, so the window may start at 0.
  if (RO_WORDS == 0) begin : g_no_ro
    assign ro_hit = 1'b0;
  end else begin : g_ro
    logic [ADDR_WIDTH:0] ro_rel;
    assign ro_rel = {1'b0, t_word} - {1'b0, RO_LO};
    assign ro_hit = !ro_rel[ADDR_WIDTH] && (ro_rel[ADDR_WIDTH-1:0] < RO_N);
  end

  // Error decode in priority order: range, alignment, write to read-only window.
  always_comb begin
    t_err = ERR_NONE;
    if (t_word >= DEPTH_A) begin
      t_err = ERR_RANGE;
    end else if ((t_addr & OFF_MASK) != '0) begin
      t_err = ERR_ALIGN;
    end else if (t_write && ro_hit) begin
      t_err = ERR_RO;
    end
  end

  assign bus_differs = (bus.PADDR  != cap_addr_q)  || (bus.PWRITE != cap_write_q) ||
                       (bus.PWDATA != cap_wdata_q) || (bus.PSTRB  != cap_strb_q);

  // Commit happens on the edge that ends RESP, and only for an error-free write.
  assign mem_we = (state_q == RESP) && cap_write_q && !pslverr_q;

  apb4_slave_mem_bytemem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk_i   (PCLK),
    .clr_i   (PRESET),
    .we_i    (mem_we),
    .widx_i  (cap_idx),
    .wdata_i (cap_wdata_q),
    .strb_i  (cap_strb_q),
    .ridx_i  (t_idx),
    .rdata_o (rd_data)
  );

  // Next-state, capture, response and protocol-check logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_addr_d  = cap_addr_q;
    cap_write_d = cap_write_q;
    cap_wdata_d = cap_wdata_q;
    cap_strb_d  = cap_strb_q;
    pready_d    = 1'b0;
    prdata_d    = '0;
    pslverr_d   = 1'b0;
    proto_d     = 1'b0;
    resp_load   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.PSEL && !bus.PENABLE) begin
          cap_addr_d  = bus.PADDR;
          cap_write_d = bus.PWRITE;
          cap_wdata_d = bus.PWDATA;
          cap_strb_d  = bus.PSTRB;
          if (WAIT_STATES == 0) begin
            resp_load = 1'b1;
            state_d   = RESP;
          end else begin
            cnt_d   = WS_RELOAD;
            state_d = WAIT;
          end
        end else if (bus.PSEL && bus.PENABLE) begin
          // Access phase with no setup phase before it.
          proto_d = 1'b1;
        end
      end

      WAIT: begin
        if (!bus.PSEL) begin
          // Requester abandoned the transfer: drop it without a response or a write.
          proto_d = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          proto_d = bus_differs;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            resp_load = 1'b1;
            state_d   = RESP;
          end
        end
      end

      RESP: begin
        proto_d = bus.PSEL && bus_differs;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (resp_load) begin
      pready_d  = 1'b1;
      pslverr_d = (t_err != ERR_NONE);
      prdata_d  = ((t_err == ERR_NONE) && !t_write) ? rd_data : '0;
    end
  end

  // State and output registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cap_addr_q  <= '0;
      cap_write_q <= 1'b0;
      cap_wdata_q <= '0;
      cap_strb_q  <= '0;
      pready_q    <= 1'b0;
      prdata_q    <= '0;
      pslverr_q   <= 1'b0;
      proto_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_addr_q  <= cap_addr_d;
      cap_write_q <= cap_write_d;
      cap_wdata_q <= cap_wdata_d;
      cap_strb_q  <= cap_strb_d;
      pready_q    <= pready_d;
      prdata_q    <= prdata_d;
      pslverr_q   <= pslverr_d;
      proto_q     <= proto_d;
    end
  end

  assign bus.PREADY  = pready_q;
  assign bus.PRDATA  = prdata_q;
  assign bus.PSLVERR = pslverr_q;
  assign proto_err   = proto_q;

endmodule
